systolic_mmu_ws: RTL and testbench

- Parametrised weight-stationary systolic matrix-multiply unit; next generation of the fixed 4x4 MMU.
- Adds:
  - ROWS x COLS generalisation;
  - synchronous reset;
  - valid/ready handshakes;
  - an explicit weight-load / compute / drain FSM;
  - internal activation skew and result de-skew, so callers send and receive aligned vectors.
- Sits between the activation/weight buffers and the accumulator SRAM of the accelerator datapath.

---
 rtl/mmu_pkg.sv | 22 ++
 rtl/systolic_mmu_ws_pe.sv | 43 ++++
 rtl/systolic_mmu_ws.sv | 175 +++++++++++++++++
 tb/tb_systolic_mmu_ws.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and helpers for the weight-stationary systolic MMU.
package mmu_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} mmu_state_e;

    // Acceptance-to-result latency: ROWS cycles down the grid plus COLS
    // cycles across it (skew + de-skew + output register).
    function automatic int mmu_lat(input int rows, input int cols);
        return rows + cols;
    endfunction

    // Extend the low w bits of v to 64 bits, sign- or zero-filling above.
    // Callers truncate the result to their own width, so w must be <= 64.
    function automatic logic [63:0] mmu_ext(input logic [63:0] v, input int w, input logic sgn);
        logic [63:0] mask;
        logic        msb;
        mask = ~64'd0 << w;
        msb  = |(v & (64'd1 << (w - 1)));
        return (sgn && msb) ? (v | mask) : (v & ~mask);
    endfunction

endpackage

// File: rtl/systolic_mmu_ws_pe.sv
// Single processing element: stationary weight, activation pass-right,
// partial-sum multiply-accumulate from the row above.
module mmu_pe
    import mmu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] act_in,
    input  logic [DATA_W-1:0] wt_in,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [DATA_W-1:0] act_out,
    output logic [DATA_W-1:0] wt_out,
    output logic [ACC_W-1:0]  psum_out
);
    localparam int    PW  = 2 * DATA_W;
    localparam logic  SGN = (SIGNED != 0);

    // Operands are widened to the full product width first, so a plain
    // PW x PW multiply truncated to PW bits is the exact product.
    logic [PW-1:0] act_x, wt_x, prod;
    assign act_x = PW'(mmu_ext(64'(act_in), DATA_W, SGN));
    assign wt_x  = PW'(mmu_ext(64'(wt_out), DATA_W, SGN));
    assign prod  = act_x * wt_x;

    // Weight shifts only on load beats; activation and psum advance every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wt_out   <= '0;
            act_out  <= '0;
            psum_out <= '0;
        end else begin
            if (shift_en) wt_out <= wt_in;
            act_out  <= act_in;
            psum_out <= psum_in + ACC_W'(mmu_ext(64'(prod), PW, SGN));
        end
    end

endmodule

// File: rtl/systolic_mmu_ws.sv
// Weight-stationary ROWS x COLS systolic matrix-multiply unit with
// load/compute/drain control, input skew and output de-skew.
module systolic_mmu_ws
    import mmu_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wt_valid,
    output logic                   wt_ready,
    input  logic [COLS*DATA_W-1:0] wt_row,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [ROWS*DATA_W-1:0] act_in,
    output logic                   out_valid,
    output logic [COLS*ACC_W-1:0]  out_acc,
    output logic                   busy
);
    localparam int LAT = mmu_lat(ROWS, COLS);
    localparam int CW  = $clog2(LAT + 1);
    localparam int BW  = (ROWS > 1) ? $clog2(ROWS) : 1;

    mmu_state_e     state;
    logic [BW-1:0]  beat;
    logic [CW-1:0]  inflight;
    logic [LAT-1:0] vld_pipe;
    logic           wt_fire, act_fire;

    assign wt_ready  = (state == IDLE) || (state == LOAD);
    assign act_ready = (state == COMPUTE);
    assign wt_fire   = wt_valid & wt_ready;
    assign act_fire  = act_valid & act_ready;
    assign busy      = (state != IDLE) && !((state == COMPUTE) && (inflight == '0));

    // Control FSM; the IDLE handshake is beat 0 of the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: if (wt_fire) begin
                    if (ROWS == 1) state <= COMPUTE;
                    else begin
                        state <= LOAD;
                        beat  <= BW'(1);
                    end
                end
                LOAD: if (wt_fire) begin
                    if (beat == BW'(ROWS - 1)) begin
                        state <= COMPUTE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                COMPUTE: if (wt_valid) state <= DRAIN;
                DRAIN:   if (inflight == '0) state <= LOAD;
                default: state <= IDLE;
            endcase
        end
    end

    // Vectors in flight: +1 on acceptance, -1 as the result is launched.
    always_ff @(posedge clk) begin
        if (rst) inflight <= '0;
        else begin
            case ({act_fire, vld_pipe[LAT-1]})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    // Per-vector valid travelling alongside the data wavefront.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[LAT-2:0], act_fire};
    end

    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] act_g, wt_g;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  psum_g;
    logic [COLS-1:0][ACC_W-1:0]            bot, dsk;
    logic [ROWS-1:0][DATA_W-1:0]           act_unused;
    logic [COLS-1:0][DATA_W-1:0]           wt_unused;

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [r:0][DATA_W-1:0] sk;
        // Row r element enters the grid r cycles late; idle slots carry zero.
        always_ff @(posedge clk) begin
            if (rst) sk <= '0;
            else begin
                sk[0] <= act_fire ? act_in[r*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= r; k++) sk[k] <= sk[k-1];
            end
        end
        assign act_g[r][0] = sk[r];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [DATA_W-1:0] a_o, w_o;
            logic [ACC_W-1:0]  p_o;

            if (r == 0) begin : g_top
                assign wt_g[0][c]   = wt_row[c*DATA_W +: DATA_W];
                assign psum_g[0][c] = '0;
            end

            mmu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .shift_en (wt_fire),
                .act_in   (act_g[r][c]),
                .wt_in    (wt_g[r][c]),
                .psum_in  (psum_g[r][c]),
                .act_out  (a_o),
                .wt_out   (w_o),
                .psum_out (p_o)
            );

            if (c < COLS - 1) begin : g_ar
                assign act_g[r][c+1] = a_o;
            end else begin : g_ae
                assign act_unused[r] = a_o;
            end

            if (r < ROWS - 1) begin : g_dn
                assign wt_g[r+1][c]   = w_o;
                assign psum_g[r+1][c] = p_o;
            end else begin : g_bt
                assign wt_unused[c] = w_o;
                assign bot[c]       = p_o;
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        if (c == COLS - 1) begin : g_thru
            assign dsk[c] = bot[c];
        end else begin : g_dly
            localparam int D = COLS - 1 - c;
            logic [D-1:0][ACC_W-1:0] ds;
            // Column c leaves the grid COLS-1-c cycles before the last column.
            always_ff @(posedge clk) begin
                if (rst) ds <= '0;
                else begin
                    ds[0] <= bot[c];
                    for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
                end
            end
            assign dsk[c] = ds[D-1];
        end
    end

    // Result register: aligned vector captured when its valid arrives, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
        end else begin
            out_valid <= vld_pipe[LAT-1];
            if (vld_pipe[LAT-1]) begin
                for (int c = 0; c < COLS; c++) out_acc[c*ACC_W +: ACC_W] <= dsk[c];
            end
        end
    end

endmodule

// File: tb/tb_systolic_mmu_ws.sv
// Self-checking bench: a signed and an unsigned MMU share stimulus; a
// matrix-multiply reference model predicts each result and its arrival cycle.
module tb_systolic_mmu_ws;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         wt_valid, act_valid;
    logic [31:0]  wt_row, act_in;
    logic         wt_ready, act_ready, out_valid, busy;
    logic [127:0] out_acc;
    logic         wt_ready_u, act_ready_u, out_valid_u, busy_u;
    logic [127:0] out_acc_u;

    systolic_mmu_ws #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
        .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
        .out_valid(out_valid), .out_acc(out_acc), .busy(busy));

    systolic_mmu_ws #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_ready(wt_ready_u), .wt_row(wt_row),
        .act_valid(act_valid), .act_ready(act_ready_u), .act_in(act_in),
        .out_valid(out_valid_u), .out_acc(out_acc_u), .busy(busy_u));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           due;
        logic [127:0] es;
        logic [127:0] eu;
    } exp_t;
    exp_t q[$];

    logic [7:0] wm [4][4];   // weights currently held by the unit
    logic [7:0] nw [4][4];   // weights to load next
    logic [7:0] av [4];      // next activation vector

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint opv(input logic [7:0] x, input bit sgn);
        if (sgn) return longint'($signed(x));
        return longint'(x);
    endfunction

    // out[c] = sum_r a[r]*W[r][c], wrapped to 32 bits
    function automatic logic [127:0] model(input bit sgn);
        logic [127:0] res;
        longint       s;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int r = 0; r < 4; r++) s += opv(av[r], sgn) * opv(wm[r][c], sgn);
            res[c*32 +: 32] = s[31:0];
        end
        return res;
    endfunction

    // Result monitor: every out_valid must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        if (out_valid || out_valid_u) begin
            chk("unexpected_out_valid", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                chk("out_latency", cyc, q[0].due);
                chk("out_valid_pair", {out_valid, out_valid_u}, 2'b11);
                chk("out_acc_signed", out_acc, q[0].es);
                chk("out_acc_unsigned", out_acc_u, q[0].eu);
                void'(q.pop_front());
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_out_valid", 1'b0, 1'b1);
            void'(q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send();
        exp_t e;
        act_valid = 1'b1;
        act_in    = {av[3], av[2], av[1], av[0]};
        chk("act_ready", act_ready, 1'b1);
        e.due = cyc + 1 + LAT;
        e.es  = model(1'b1);
        e.eu  = model(1'b0);
        q.push_back(e);
        @(negedge clk);
        act_valid = 1'b0;
    endtask

    // Beat k carries the row that ends up in PE row 3-k.
    task automatic load_w();
        int n;
        for (int k = 0; k < 4; k++) begin
            wt_valid = 1'b1;
            wt_row   = {nw[3-k][3], nw[3-k][2], nw[3-k][1], nw[3-k][0]};
            n = 0;
            while (wt_ready !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
                if (wt_ready !== 1'b1) chk("drain_act_ready", act_ready, 1'b0);
            end
            chk("wt_ready_wait", n < 60, 1'b1);
            if (k == 0 && n > 0) chk("drained_before_reload", q.size(), 0);
            @(negedge clk);
            if (k < 3) chk("busy_in_load", busy, 1'b1);
        end
        wt_valid = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wm[r][c] = nw[r][c];
        chk("compute_act_ready", act_ready, 1'b1);
        chk("compute_wt_ready", wt_ready, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 100, 1'b1);
    endtask

    task automatic chk_reset_state();
        chk("rst_wt_ready", {wt_ready, wt_ready_u}, 2'b11);
        chk("rst_act_ready", {act_ready, act_ready_u}, 2'b00);
        chk("rst_out_valid", {out_valid, out_valid_u}, 2'b00);
        chk("rst_out_acc", out_acc, 128'd0);
        chk("rst_out_acc_u", out_acc_u, 128'd0);
        chk("rst_busy", {busy, busy_u}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wt_valid = 1'b0; act_valid = 1'b0; wt_row = '0; act_in = '0;
        idle(3);
        rst = 1'b0;
        chk_reset_state();

        // identity weights, act {1,2,3,4}
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) nw[r][c] = (r == c) ? 8'd1 : 8'd0;
        load_w();
        chk("busy_compute_empty", busy, 1'b0);
        av = '{8'd1, 8'd2, 8'd3, 8'd4};
        send();
        chk("busy_in_flight", busy, 1'b1);
        wait_drain();

        // W[r][c] = r*4+c+1, back-to-back {1,1,1,1} and {1,0,0,0}
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) nw[r][c] = 8'(r * 4 + c + 1);
        load_w();
        av = '{8'd1, 8'd1, 8'd1, 8'd1};
        send();
        av = '{8'd1, 8'd0, 8'd0, 8'd0};
        send();
        wait_drain();

        // -128 x -128 (signed) / 128 x 128 (unsigned)
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) nw[r][c] = 8'h80;
        load_w();
        av = '{8'h80, 8'h80, 8'h80, 8'h80};
        send();
        wait_drain();

        // bubbles: random vectors with 2-cycle gaps, random weights
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) nw[r][c] = 8'($urandom);
        load_w();
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++) av[r] = 8'($urandom);
            send();
            idle(2);
        end
        wait_drain();
        idle(1);
        chk("busy_idle_compute", busy, 1'b0);

        // reload while 3 vectors are in flight
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++) av[r] = 8'($urandom);
            send();
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) nw[r][c] = 8'($urandom);
        load_w();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 4; r++) av[r] = 8'($urandom);
            send();
        end
        wait_drain();

        // reset with vectors in flight
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++) av[r] = 8'($urandom);
            send();
        end
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        #1 q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state();
        idle(LAT + 4);
        chk("post_reset_quiet_acc", out_acc, 128'd0);

        // fresh load + randomized traffic with random gaps
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) nw[r][c] = 8'($urandom);
        load_w();
        for (int i = 0; i < 20; i++) begin
            for (int r = 0; r < 4; r++) av[r] = 8'($urandom);
            send();
            idle($urandom_range(0, 2));
        end
        wait_drain();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
